// File: rtl/rv32i_types.sv
// Shared types for the memory responder: the arbiter states and the port selector.
package rv32i_types;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } mem_resp_state_t;

  typedef enum logic {
    SEL_IMEM,
    SEL_DMEM
  } port_sel_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/req_slot.sv
// One-entry capture slot for a memory request; capture wins over clear so a
// port can hand over a new request in the same cycle its response issues.
module req_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_rmask,
  input  logic [3:0]  req_wmask,
  input  logic [31:0] req_wdata,
  output logic        valid,
  output logic [31:0] addr,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= 32'h0;
      rmask <= 4'h0;
      wmask <= 4'h0;
      wdata <= 32'h0;
    end else if (capture) begin
      valid <= 1'b1;
      addr  <= req_addr;
      rmask <= req_rmask;
      wmask <= req_wmask;
      wdata <= req_wdata;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Arbitrates an instruction port and a data port onto one backing memory port,
// one transaction at a time. Valid/ready: bmem_req holds with a stable command
// until bmem_ack; each resp is a single-cycle pulse with its rdata valid alongside.
module mem_responder
  import rv32i_types::*;
#(
  parameter int unsigned IMEM_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     imem_addr,
  input  logic [3:0]      imem_rmask,
  output logic [31:0]     imem_rdata,
  output logic            imem_resp,
  input  logic [31:0]     dmem_addr,
  input  logic [3:0]      dmem_rmask,
  input  logic [3:0]      dmem_wmask,
  input  logic [31:0]     dmem_wdata,
  output logic [31:0]     dmem_rdata,
  output logic            dmem_resp,
  output logic [31:0]     bmem_addr,
  output logic            bmem_req,
  output logic            bmem_we,
  output logic [3:0]      bmem_wmask,
  output logic [31:0]     bmem_wdata,
  input  logic [31:0]     bmem_rdata,
  input  logic            bmem_ack,
  output mem_resp_state_t state
);

  mem_resp_state_t cur_state, next_state;
  port_sel_t       winner, next_winner;

  logic        i_valid, d_valid;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata;
  logic [3:0]  i_rmask, d_rmask, i_wmask, d_wmask;
  logic        i_cap, d_cap, i_pend, d_pend;

  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_rmask, sel_wmask;
  logic        issuing;
  logic [31:0] imem_rdata_q, dmem_rdata_q;

  // A busy slot only accepts a new request while its own response is issuing.
  assign i_cap  = !rst && (imem_rmask != 4'h0) && (!i_valid || imem_resp);
  assign d_cap  = !rst && ((dmem_rmask | dmem_wmask) != 4'h0) && (!d_valid || dmem_resp);
  assign i_pend = i_valid || i_cap;
  assign d_pend = d_valid || d_cap;

  req_slot u_imem_slot (
    .clk       (clk),
    .rst       (rst),
    .capture   (i_cap),
    .clear     (imem_resp),
    .req_addr  (imem_addr),
    .req_rmask (imem_rmask),
    .req_wmask (4'h0),
    .req_wdata (32'h0),
    .valid     (i_valid),
    .addr      (i_addr),
    .rmask     (i_rmask),
    .wmask     (i_wmask),
    .wdata     (i_wdata)
  );

  req_slot u_dmem_slot (
    .clk       (clk),
    .rst       (rst),
    .capture   (d_cap),
    .clear     (dmem_resp),
    .req_addr  (dmem_addr),
    .req_rmask (dmem_rmask),
    .req_wmask (dmem_wmask),
    .req_wdata (dmem_wdata),
    .valid     (d_valid),
    .addr      (d_addr),
    .rmask     (d_rmask),
    .wmask     (d_wmask),
    .wdata     (d_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ARB_IDLE;
      winner    <= SEL_IMEM;
    end else begin
      cur_state <= next_state;
      winner    <= next_winner;
    end
  end

  // Incoming requests count as pending so a fresh request reaches bmem one cycle later.
  always_comb begin
    next_state  = cur_state;
    next_winner = winner;
    case (cur_state)
      ARB_IDLE: begin
        if (i_pend && d_pend) begin
          next_winner = (IMEM_FIRST != 0) ? SEL_IMEM : SEL_DMEM;
          next_state  = ARB_ISSUE;
        end else if (i_pend) begin
          next_winner = SEL_IMEM;
          next_state  = ARB_ISSUE;
        end else if (d_pend) begin
          next_winner = SEL_DMEM;
          next_state  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (bmem_ack) next_state = ARB_RESP;
      end
      ARB_RESP: begin
        // The other port goes first so neither can starve; a same-cycle
        // re-request from the winner is otherwise issued without an idle bubble.
        if (winner == SEL_IMEM && d_pend) begin
          next_winner = SEL_DMEM;
          next_state  = ARB_ISSUE;
        end else if (winner == SEL_DMEM && i_pend) begin
          next_winner = SEL_IMEM;
          next_state  = ARB_ISSUE;
        end else if ((winner == SEL_IMEM && i_cap) || (winner == SEL_DMEM && d_cap)) begin
          next_state = ARB_ISSUE;
        end else begin
          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  assign sel_addr  = (winner == SEL_IMEM) ? i_addr  : d_addr;
  assign sel_rmask = (winner == SEL_IMEM) ? i_rmask : d_rmask;
  assign sel_wmask = (winner == SEL_IMEM) ? i_wmask : d_wmask;
  assign sel_wdata = (winner == SEL_IMEM) ? i_wdata : d_wdata;
  assign issuing   = (cur_state == ARB_ISSUE);

  assign bmem_req   = issuing;
  assign bmem_addr  = issuing ? (sel_addr & WORD_ALIGN_MASK) : 32'h0;
  assign bmem_we    = issuing && (sel_wmask != 4'h0);
  assign bmem_wmask = issuing ? sel_wmask : 4'h0;
  assign bmem_wdata = issuing ? sel_wdata : 32'h0;

  // A request with any write byte is a store and returns zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_rdata_q <= 32'h0;
      dmem_rdata_q <= 32'h0;
    end else if (issuing && bmem_ack) begin
      if (winner == SEL_IMEM) imem_rdata_q <= bmem_rdata;
      else dmem_rdata_q <= ((sel_rmask != 4'h0) && (sel_wmask == 4'h0)) ? bmem_rdata : 32'h0;
    end
  end

  assign imem_resp  = (cur_state == ARB_RESP) && (winner == SEL_IMEM);
  assign dmem_resp  = (cur_state == ARB_RESP) && (winner == SEL_DMEM);
  assign imem_rdata = imem_rdata_q;
  assign dmem_rdata = dmem_rdata_q;
  assign state      = cur_state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a backing-memory model with selectable ack
// latency plus response and command scoreboards fed by the stimulus.
module tb_mem_responder;
  import rv32i_types::*;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } cmd_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     imem_addr, dmem_addr, dmem_wdata, bmem_rdata;
  logic [3:0]      imem_rmask, dmem_rmask, dmem_wmask;
  logic [31:0]     imem_rdata, dmem_rdata, bmem_addr, bmem_wdata;
  logic            imem_resp, dmem_resp, bmem_req, bmem_we, bmem_ack;
  logic [3:0]      bmem_wmask;
  mem_resp_state_t state_dbg;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_lat = 1;
  int req_cycles = 0;
  logic auto_ack = 1'b0;
  logic force_ack = 1'b0;
  int imem_resp_n = 0, dmem_resp_n = 0;
  int imem_resp_cyc = 0, dmem_resp_cyc = 0;

  logic [31:0] exp_imem_q[$];
  logic [31:0] exp_dmem_q[$];
  cmd_t        exp_cmd_q[$];

  assign bmem_ack = auto_ack | force_ack;

  mem_responder #(.IMEM_FIRST(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .bmem_addr  (bmem_addr),
    .bmem_req   (bmem_req),
    .bmem_we    (bmem_we),
    .bmem_wmask (bmem_wmask),
    .bmem_wdata (bmem_wdata),
    .bmem_rdata (bmem_rdata),
    .bmem_ack   (bmem_ack),
    .state      (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h6000_0004) return 32'h1234_5678;
    return a ^ 32'hC0DE_0000;
  endfunction

  // backing memory: ack after ack_lat cycles of bmem_req (0 = never), checking each command
  always @(negedge clk) begin
    auto_ack = 1'b0;
    if (rst || !bmem_req) begin
      req_cycles = 0;
    end else begin
      req_cycles++;
      if (req_cycles == ack_lat) begin
        auto_ack   = 1'b1;
        bmem_rdata = mem_word(bmem_addr);
        if (exp_cmd_q.size() == 0) begin
          check("cmd_unexpected", 32'd1, 32'd0);
        end else begin
          cmd_t c;
          c = exp_cmd_q.pop_front();
          check("cmd_addr", bmem_addr, c.addr);
          check("cmd_we", 32'(bmem_we), 32'(c.we));
          check("cmd_wmask", 32'(bmem_wmask), 32'(c.wmask));
          check("cmd_wdata", bmem_wdata, c.wdata);
        end
      end
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_resp && dmem_resp) check("both_resp", 32'd1, 32'd0);
      if (imem_resp) begin
        imem_resp_n++;
        imem_resp_cyc = cyc;
        if (exp_imem_q.size() == 0) check("imem_unexpected", 32'd1, 32'd0);
        else check("imem_rdata_sb", imem_rdata, exp_imem_q.pop_front());
      end
      if (dmem_resp) begin
        dmem_resp_n++;
        dmem_resp_cyc = cyc;
        if (exp_dmem_q.size() == 0) check("dmem_unexpected", 32'd1, 32'd0);
        else check("dmem_rdata_sb", dmem_rdata, exp_dmem_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_rmask = 4'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
    dmem_wdata = 32'h0;
  endtask

  task automatic drive_imem(input logic [31:0] a);
    imem_addr  = a;
    imem_rmask = 4'hF;
  endtask

  task automatic drive_dmem(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                            input logic [31:0] wd);
    dmem_addr  = a;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
  endtask

  task automatic wait_resp(input int ni, input int nd, input string name);
    int done;
    done = 0;
    for (int k = 0; k < 40; k++) begin
      if (imem_resp_n >= ni && dmem_resp_n >= nd) begin
        done = 1;
        break;
      end
      tick();
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    int ni0, nd0;
    rst        = 1'b1;
    imem_addr  = 32'h0;
    dmem_addr  = 32'h0;
    bmem_rdata = 32'h0;
    idle_inputs();
    tick();
    tick();
    check("rst_state", 32'(state_dbg), 32'(ARB_IDLE));
    check("rst_bmem_req", 32'(bmem_req), 32'd0);
    check("rst_bmem_addr", bmem_addr, 32'h0);
    check("rst_imem_resp", 32'(imem_resp), 32'd0);
    check("rst_dmem_resp", 32'(dmem_resp), 32'd0);
    check("rst_imem_rdata", imem_rdata, 32'h0);
    check("rst_dmem_rdata", dmem_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // single fetch, ack in the first issue cycle
    ack_lat = 1;
    drive_imem(32'h6000_0006);
    exp_imem_q.push_back(32'h1234_5678);
    exp_cmd_q.push_back('{addr: 32'h6000_0004, we: 1'b0, wmask: 4'h0, wdata: 32'h0});
    tick();
    idle_inputs();
    check("fetch_c1_req", 32'(bmem_req), 32'd1);
    check("fetch_c1_addr", bmem_addr, 32'h6000_0004);
    check("fetch_c1_we", 32'(bmem_we), 32'd0);
    tick();
    check("fetch_c2_resp", 32'(imem_resp), 32'd1);
    check("fetch_c2_rdata", imem_rdata, 32'h1234_5678);
    tick();
    check("fetch_c3_resp", 32'(imem_resp), 32'd0);
    check("fetch_c3_state", 32'(state_dbg), 32'(ARB_IDLE));
    check("fetch_rdata_hold", imem_rdata, 32'h1234_5678);

    // simultaneous read requests, dmem wins the tie
    ack_lat = 3;
    ni0 = imem_resp_n;
    nd0 = dmem_resp_n;
    drive_imem(32'h0000_0100);
    drive_dmem(32'h0000_0204, 4'hF, 4'h0, 32'h0);
    exp_cmd_q.push_back('{addr: 32'h0000_0204, we: 1'b0, wmask: 4'h0, wdata: 32'h0});
    exp_cmd_q.push_back('{addr: 32'h0000_0100, we: 1'b0, wmask: 4'h0, wdata: 32'h0});
    exp_dmem_q.push_back(32'hC0DE_0204);
    exp_imem_q.push_back(32'hC0DE_0100);
    tick();
    idle_inputs();
    wait_resp(ni0 + 1, nd0 + 1, "sim_timeout");
    check("sim_order_gap", 32'(imem_resp_cyc - dmem_resp_cyc), 32'd4);

    // store, then combined read+write treated as store, address word-aligned
    ack_lat = 2;
    tick();
    nd0 = dmem_resp_n;
    drive_dmem(32'h0000_0300, 4'h0, 4'h3, 32'hDEAD_BEEF);
    exp_cmd_q.push_back('{addr: 32'h0000_0300, we: 1'b1, wmask: 4'h3, wdata: 32'hDEAD_BEEF});
    exp_dmem_q.push_back(32'h0);
    tick();
    idle_inputs();
    check("store_we", 32'(bmem_we), 32'd1);
    check("store_wmask", 32'(bmem_wmask), 32'h3);
    check("store_wdata", bmem_wdata, 32'hDEAD_BEEF);
    wait_resp(0, nd0 + 1, "store_timeout");
    check("store_rdata", dmem_rdata, 32'h0);
    check("imem_rdata_hold", imem_rdata, 32'hC0DE_0100);
    tick();
    drive_dmem(32'h0000_030A, 4'hF, 4'hF, 32'h0BAD_F00D);
    exp_cmd_q.push_back('{addr: 32'h0000_0308, we: 1'b1, wmask: 4'hF, wdata: 32'h0BAD_F00D});
    exp_dmem_q.push_back(32'h0);
    tick();
    idle_inputs();
    wait_resp(0, nd0 + 2, "rw_timeout");

    // back-to-back fetch issued in the resp cycle
    ack_lat = 1;
    tick();
    drive_imem(32'h0000_0400);
    exp_imem_q.push_back(32'hC0DE_0400);
    exp_cmd_q.push_back('{addr: 32'h0000_0400, we: 1'b0, wmask: 4'h0, wdata: 32'h0});
    tick();
    idle_inputs();
    tick();
    check("b2b_first_resp", 32'(imem_resp), 32'd1);
    drive_imem(32'h0000_0408);
    exp_imem_q.push_back(32'hC0DE_0408);
    exp_cmd_q.push_back('{addr: 32'h0000_0408, we: 1'b0, wmask: 4'h0, wdata: 32'h0});
    tick();
    idle_inputs();
    check("b2b_req_next", 32'(bmem_req), 32'd1);
    check("b2b_addr_next", bmem_addr, 32'h0000_0408);
    tick();
    check("b2b_second_resp", 32'(imem_resp), 32'd1);

    // duplicate fetch while the first is pending is ignored
    ack_lat = 3;
    tick();
    ni0 = imem_resp_n;
    drive_imem(32'h0000_0500);
    exp_imem_q.push_back(32'hC0DE_0500);
    exp_cmd_q.push_back('{addr: 32'h0000_0500, we: 1'b0, wmask: 4'h0, wdata: 32'h0});
    tick();
    drive_imem(32'h0000_0504);
    tick();
    idle_inputs();
    wait_resp(ni0 + 1, 0, "dup_timeout");
    for (int k = 0; k < 6; k++) tick();
    check("dup_resp_count", 32'(imem_resp_n - ni0), 32'd1);
    check("dup_cmd_left", 32'(exp_cmd_q.size()), 32'd0);

    // reset during issue, late ack, and a request presented during reset
    ack_lat = 0;
    ni0 = imem_resp_n;
    nd0 = dmem_resp_n;
    drive_imem(32'h0000_0600);
    tick();
    idle_inputs();
    check("rstmid_state_issue", 32'(state_dbg), 32'(ARB_ISSUE));
    check("rstmid_req", 32'(bmem_req), 32'd1);
    rst = 1'b1;
    drive_dmem(32'h0000_0700, 4'hF, 4'h0, 32'h0);
    tick();
    rst = 1'b0;
    idle_inputs();
    force_ack = 1'b1;
    check("rstmid_req_drop", 32'(bmem_req), 32'd0);
    check("rstmid_state_idle", 32'(state_dbg), 32'(ARB_IDLE));
    tick();
    force_ack = 1'b0;
    check("late_ack_state", 32'(state_dbg), 32'(ARB_IDLE));
    check("late_ack_imem_rdata", imem_rdata, 32'h0);
    check("late_ack_dmem_rdata", dmem_rdata, 32'h0);
    for (int k = 0; k < 4; k++) begin
      check("post_rst_req", 32'(bmem_req), 32'd0);
      tick();
    end
    check("post_rst_resp", 32'((imem_resp_n - ni0) + (dmem_resp_n - nd0)), 32'd0);

    check("end_imem_q", 32'(exp_imem_q.size()), 32'd0);
    check("end_dmem_q", 32'(exp_dmem_q.size()), 32'd0);
    check("end_cmd_q", 32'(exp_cmd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
